fmap_packer: RTL and testbench

Streaming-to-parallel feature-map loader that feeds the flat `x` bus of the SPP/CBS pipeline. It accepts one DATA_WIDTH word per handshake from a valid/ready pixel stream and packs D*H*W words into a single flat vector. It holds that vector stable with `x_valid` high until the consumer acknowledges it. It is the writer side of the flat feature-map interface that the convolution blocks read.

---
 rtl/fmap_pkg.sv | 21 ++
 rtl/fmap_packer.sv | 89 ++++++++
 tb/tb_fmap_packer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_pkg.sv
// Shared types and helpers for the flat feature-map packer.
package fmap_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic {
    StFill,
    StFull
  } state_e;

  // Equivalent to $clog2(n + 1): bits needed to count 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < (64'(n) + 64'd1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fmap_packer.sv
// Packs D*H*W stream words into one flat x vector and holds it until x_ack.
// Define LAST_CHECK_EN to add the s_last input and sticky frame_err output.
module fmap_packer #(
  parameter int unsigned DATA_WIDTH = fmap_pkg::DATA_WIDTH,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 2,
  parameter int unsigned W          = 2,
  localparam int unsigned N         = D * H * W,
  localparam int unsigned CNT_W     = fmap_pkg::cnt_width(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
`ifdef LAST_CHECK_EN
  input  logic                    s_last,
  output logic                    frame_err,
`endif
  output logic [0:N*DATA_WIDTH-1] x,
  output logic                    x_valid,
  input  logic                    x_ack,
  output logic [CNT_W-1:0]        fill_cnt
);
  import fmap_pkg::*;

  state_e                   state_q;
  logic [CNT_W-1:0]         fill_cnt_q;
  logic [0:N*DATA_WIDTH-1]  x_q;
  logic                     x_valid_q;
  logic                     s_ready_q;
  logic                     last_word;
`ifdef LAST_CHECK_EN
  logic                     frame_err_q;
`endif

  assign last_word = (fill_cnt_q == CNT_W'(N - 1));

  // s_ready is a registered decode of the next state, held low for one cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFill;
      fill_cnt_q  <= '0;
      x_q         <= '0;
      x_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
`ifdef LAST_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFill: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            x_q[int'(fill_cnt_q) * DATA_WIDTH +: DATA_WIDTH] <= s_data;
`ifdef LAST_CHECK_EN
            if (s_last != last_word) frame_err_q <= 1'b1;
`endif
            if (last_word) begin
              state_q    <= StFull;
              fill_cnt_q <= '0;
              s_ready_q  <= 1'b0;
              x_valid_q  <= 1'b1;
            end else begin
              fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
          end
        end
        StFull: begin
          if (x_ack) begin
            state_q   <= StFill;
            x_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign s_ready  = s_ready_q;
  assign fill_cnt = fill_cnt_q;
`ifdef LAST_CHECK_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_fmap_packer.sv
// Randomized scoreboard bench for fmap_packer; the model packs accepted words arithmetically.
module tb_fmap_packer;

  localparam int unsigned DW    = 16;
  localparam int unsigned D     = 1;
  localparam int unsigned H     = 2;
  localparam int unsigned W     = 2;
  localparam int unsigned N     = D * H * W;
  localparam int unsigned NW    = N * DW;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned CW    = (NW > 32) ? NW : 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_ready;
  logic [0:NW-1]      x;
  logic               x_valid;
  logic               x_ack;
  logic [CNT_W-1:0]   fill_cnt;
`ifdef LAST_CHECK_EN
  logic               s_last;
  logic               frame_err;
  logic               inject = 1'b0;
  logic               m_err = 1'b0;
`endif

  fmap_packer #(
    .DATA_WIDTH (DW),
    .D          (D),
    .H          (H),
    .W          (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
`ifdef LAST_CHECK_EN
    .s_last   (s_last),
    .frame_err(frame_err),
`endif
    .x        (x),
    .x_valid  (x_valid),
    .x_ack    (x_ack),
    .fill_cnt (fill_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected frame is the N accepted words, first word most significant.
  logic [NW-1:0] sb_q[$];
  logic [NW-1:0] m_acc   = '0;
  int            m_cnt   = 0;
  bit            m_full  = 1'b0;
  bit            m_start = 1'b0;
  int            cyc     = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_cnt = 0; m_full = 1'b0; m_start = 1'b0; m_acc = '0;
      sb_q.delete();
`ifdef LAST_CHECK_EN
      m_err = 1'b0;
`endif
    end else begin
      cyc++;
      if (m_full) begin
        if (x_ack) m_full = 1'b0;
      end else if (s_valid && s_ready) begin
`ifdef LAST_CHECK_EN
        if (s_last != (m_cnt == N - 1)) m_err = 1'b1;
`endif
        m_acc = (m_acc << DW) | NW'(s_data);
        m_cnt++;
        if (m_cnt == N) begin
          sb_q.push_back(m_acc);
          m_full = 1'b1;
          m_cnt  = 0;
          m_acc  = '0;
        end
      end
      m_start = 1'b1;
    end
  end

  // Monitor: pops a frame when x_valid rises and checks it stays frozen while held.
  logic [NW-1:0] cur_exp = '0;
  bit            prev_xv = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      prev_xv = 1'b0;
    end else begin
      chk("fill_cnt", CW'(fill_cnt), CW'(m_cnt));
      chk("x_valid", CW'(x_valid), CW'(m_full));
      chk("s_ready", CW'(s_ready), CW'(m_start && !m_full));
`ifdef LAST_CHECK_EN
      chk("frame_err", CW'(frame_err), CW'(m_err));
`endif
      if (x_valid && !prev_xv) begin
        if (sb_q.size() == 0) begin
          chk("frame_expected", CW'(1), CW'(0));
        end else begin
          cur_exp = sb_q.pop_front();
          chk("frame", CW'(x), CW'(cur_exp));
        end
      end else if (x_valid) begin
        chk("hold", CW'(x), CW'(cur_exp));
      end
      prev_xv = x_valid;
    end
  end

  // Driver
  int ack_mode = 0;  // 0: driver-controlled, 1: random, 2: always high
  int drv_idx  = 0;

  task automatic tick();
    @(negedge clk);
    x_ack = (ack_mode == 2) || (ack_mode == 1 && $urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    repeat (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = d;
`ifdef LAST_CHECK_EN
    s_last  = (drv_idx == N - 1) ^ (inject && drv_idx == 2);
`endif
    for (int i = 0; !s_ready; i++) begin
      if (i == 500) begin
        chk("ready_timeout", CW'(0), CW'(1));
        s_valid = 1'b0;
        return;
      end
      tick();
    end
    tick();
    s_valid = 1'b0;
    drv_idx = (drv_idx + 1) % N;
  endtask

  task automatic check_reset_vals();
    chk("rst_fill_cnt", CW'(fill_cnt), CW'(0));
    chk("rst_x", CW'(x), CW'(0));
    chk("rst_x_valid", CW'(x_valid), CW'(0));
    chk("rst_s_ready", CW'(s_ready), CW'(0));
`ifdef LAST_CHECK_EN
    chk("rst_frame_err", CW'(frame_err), CW'(0));
`endif
  endtask

  int t0;
  int t1;

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    x_ack   = 1'b0;
`ifdef LAST_CHECK_EN
    s_last  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1 check_reset_vals();
    @(negedge clk);
    #2 reset = 1'b1;

    // Back-to-back 1..4 with no ack, then stall 0xAAAA in FULL and release with one ack pulse.
    ack_mode = 0;
    tick();
    for (int i = 1; i <= int'(N); i++) send(DW'(i), 0);
    s_valid = 1'b1;
    s_data  = 16'hAAAA;
    repeat (5) tick();
    x_ack = 1'b1;
    tick();
    send(16'hAAAA, 0);
    for (int i = 1; i < int'(N); i++) send(DW'($urandom), 0);

    // s_valid toggling every other cycle.
    ack_mode = 2;
    for (int i = 1; i <= int'(N); i++) send(DW'(i), 1);

    // Minimum frame period with ack on the first FULL cycle.
    send(16'h1111, 0);
    t0 = cyc;
    for (int i = 1; i < int'(N); i++) send(DW'($urandom), 0);
    send(16'h2222, 0);
    t1 = cyc;
    for (int i = 1; i < int'(N); i++) send(DW'($urandom), 0);
    chk("period", CW'(t1 - t0), CW'(N + 1));

`ifdef LAST_CHECK_EN
    inject = 1'b1;
    for (int i = 0; i < int'(N); i++) send(DW'($urandom), 0);
    inject = 1'b0;
    chk("frame_err_set", CW'(frame_err), CW'(1));
    for (int i = 0; i < int'(N); i++) send(DW'($urandom), 0);
    chk("frame_err_sticky", CW'(frame_err), CW'(1));
`endif

    // Asynchronous reset after 2 words: values must clear with no clock edge.
    send(16'h5A5A, 0);
    send(16'hA5A5, 0);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    drv_idx = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    tick();
    for (int i = 1; i <= int'(N); i++) send(DW'(16'h0100 + i), 0);

    // Randomized frames, gaps and ack timing.
    ack_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < int'(N); i++) send(DW'($urandom), $urandom_range(0, 2));
    end

    ack_mode = 2;
    repeat (4) tick();
    chk("sb_empty", CW'(sb_q.size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
